// File: rtl/arith_op_sequencer.sv
// arith_op_sequencer: issue/capture front end for the 4-bit arithmetic unit.
// Registers operands, waits a settle time, samples D/COUT, keeps op statistics.
module arith_op_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    input  logic [1:0]       cmd_s,
    input  logic             cmd_cin,
    input  logic             cmd_a,
    input  logic             cmd_b,
    output logic [WIDTH-1:0] au_x,
    output logic [WIDTH-1:0] au_y,
    output logic [1:0]       au_s,
    output logic             au_cin,
    output logic             au_a,
    output logic             au_b,
    input  logic [WIDTH-1:0] au_d,
    input  logic             au_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_d,
    output logic             res_cout,
    output logic [1:0]       res_s,
    output logic             busy,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] carry_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE
    } state_t;

    localparam logic [3:0] CNT_LD = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_n;
    logic [3:0] cnt;
    logic       accept;
    logic       slot_free;
    logic       capture;

    assign cmd_ready = (state == ST_IDLE) && rst_n;
    assign busy      = (state != ST_IDLE);
    assign accept    = (state == ST_IDLE) && cmd_valid;
    assign slot_free = !res_valid || res_ready;
    assign capture   = (state == ST_CAPTURE) && slot_free;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next-state: settle countdown, then wait in CAPTURE for a free slot.
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:    if (cmd_valid) state_n = ST_SETTLE;
            ST_SETTLE:  if (cnt == 4'd0) state_n = ST_CAPTURE;
            ST_CAPTURE: if (slot_free) state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // Settle counter: loaded on accept, counts down while settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= CNT_LD;
        end else if (state == ST_SETTLE && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Operand registers: loaded on accept, held until the next command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            au_x   <= '0;
            au_y   <= '0;
            au_s   <= 2'd0;
            au_cin <= 1'b0;
            au_a   <= 1'b0;
            au_b   <= 1'b0;
        end else if (accept) begin
            au_x   <= cmd_x;
            au_y   <= cmd_y;
            au_s   <= cmd_s;
            au_cin <= cmd_cin;
            au_a   <= cmd_a;
            au_b   <= cmd_b;
        end
    end

    // Result slot: a capture overrides a coincident pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_d     <= '0;
            res_cout  <= 1'b0;
            res_s     <= 2'd0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_d     <= au_d;
            res_cout  <= au_cout;
            res_s     <= au_s;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Statistics: clear wins over a coincident capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count    <= '0;
            carry_count <= '0;
        end else if (stat_clr) begin
            op_count    <= '0;
            carry_count <= '0;
        end else if (capture) begin
            op_count    <= op_count + CNT_W'(1);
            carry_count <= carry_count + CNT_W'(au_cout);
        end
    end

endmodule

// File: tb/tb_arith_op_sequencer.sv
// tb_arith_op_sequencer: directed tests for the arithmetic op sequencer.
// Two instances: SETTLE=1/CNT_W=8 and SETTLE=3/CNT_W=2.
module tb_arith_op_sequencer;

    logic clk;
    int   passed = 0;
    int   total  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] au_fn(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic [1:0] s,
        input logic       c
    );
        logic [4:0] r;
        case (s)
            2'd0:    r = {1'b0, x} + 5'(c);
            2'd1:    r = {1'b0, x} + {1'b0, y} + 5'(c);
            2'd2:    r = {1'b0, x} + {1'b0, ~y} + 5'(c);
            default: r = {1'b0, x} + 5'h0F + 5'(c);
        endcase
        return r;
    endfunction

    // ---------------- instance A: SETTLE=1, CNT_W=8
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_x, cmd_y;
    logic [1:0] cmd_s;
    logic       cmd_cin, cmd_a, cmd_b;
    logic [3:0] au_x, au_y, au_d;
    logic [1:0] au_s;
    logic       au_cin, au_a, au_b, au_cout;
    logic       res_valid, res_ready, res_cout, busy, stat_clr;
    logic [3:0] res_d;
    logic [1:0] res_s;
    logic [7:0] op_count, carry_count;

    assign {au_cout, au_d} = au_fn(au_x, au_y, au_s, au_cin);

    arith_op_sequencer #(.WIDTH(4), .SETTLE(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_s(cmd_s),
        .cmd_cin(cmd_cin), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .au_x(au_x), .au_y(au_y), .au_s(au_s),
        .au_cin(au_cin), .au_a(au_a), .au_b(au_b),
        .au_d(au_d), .au_cout(au_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_d(res_d), .res_cout(res_cout), .res_s(res_s),
        .busy(busy), .stat_clr(stat_clr),
        .op_count(op_count), .carry_count(carry_count)
    );

    // ---------------- instance B: SETTLE=3, CNT_W=2
    logic       b_rst_n;
    logic       b_cmd_valid, b_cmd_ready;
    logic [3:0] b_cmd_x, b_cmd_y;
    logic [1:0] b_cmd_s;
    logic       b_cmd_cin;
    logic [3:0] b_au_x, b_au_y, b_au_d;
    logic [1:0] b_au_s;
    logic       b_au_cin, b_au_a, b_au_b, b_au_cout;
    logic       b_res_valid, b_res_ready, b_res_cout, b_busy, b_stat_clr;
    logic [3:0] b_res_d;
    logic [1:0] b_res_s;
    logic [1:0] b_op_count, b_carry_count;

    assign {b_au_cout, b_au_d} = au_fn(b_au_x, b_au_y, b_au_s, b_au_cin);

    arith_op_sequencer #(.WIDTH(4), .SETTLE(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_x(b_cmd_x), .cmd_y(b_cmd_y), .cmd_s(b_cmd_s),
        .cmd_cin(b_cmd_cin), .cmd_a(1'b1), .cmd_b(1'b1),
        .au_x(b_au_x), .au_y(b_au_y), .au_s(b_au_s),
        .au_cin(b_au_cin), .au_a(b_au_a), .au_b(b_au_b),
        .au_d(b_au_d), .au_cout(b_au_cout),
        .res_valid(b_res_valid), .res_ready(b_res_ready),
        .res_d(b_res_d), .res_cout(b_res_cout), .res_s(b_res_s),
        .busy(b_busy), .stat_clr(b_stat_clr),
        .op_count(b_op_count), .carry_count(b_carry_count)
    );

    // Drive one command on A; returns at the negedge after the accept edge.
    task automatic send_a(
        input logic [3:0] x, input logic [3:0] y,
        input logic [1:0] s, input logic c
    );
        int n = 0;
        @(negedge clk);
        cmd_x = x; cmd_y = y; cmd_s = s; cmd_cin = c;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            total++;
            $display("FAIL send_a_timeout: cmd_ready=%b want 1", cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_x = 4'h0; cmd_y = 4'h0;
        end
    endtask

    // Drive one command on B; returns at the negedge after the accept edge.
    task automatic send_b(
        input logic [3:0] x, input logic [3:0] y,
        input logic [1:0] s, input logic c
    );
        int n = 0;
        @(negedge clk);
        b_cmd_x = x; b_cmd_y = y; b_cmd_s = s; b_cmd_cin = c;
        b_cmd_valid = 1'b1;
        while (!b_cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!b_cmd_ready) begin
            total++;
            $display("FAIL send_b_timeout: cmd_ready=%b want 1", b_cmd_ready);
            b_cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            b_cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({res_valid, busy, op_count, carry_count} !== 18'd0)
            $display("FAIL rst_state: v=%b busy=%b op=%0d cc=%0d want 0",
                     res_valid, busy, op_count, carry_count);
        else passed++;
        total++;
        if ({au_x, au_y, au_s, au_cin, au_a, au_b, res_d, res_cout, res_s} !== 20'd0)
            $display("FAIL rst_regs: au_x=%h res_d=%h want 0", au_x, res_d);
        else passed++;
        rst_n = 1'b1;
        b_rst_n = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b1 || b_cmd_ready !== 1'b1)
            $display("FAIL rst_ready: a=%b b=%b want 1", cmd_ready, b_cmd_ready);
        else passed++;
    endtask

    task automatic test_add();
        cmd_a = 1'b1; cmd_b = 1'b0;
        send_a(4'd9, 4'd3, 2'b01, 1'b0);
        total++;
        if (au_x !== 4'd9 || au_a !== 1'b1 || au_b !== 1'b0)
            $display("FAIL add_regs: au_x=%h a=%b b=%b want 9 1 0", au_x, au_a, au_b);
        else passed++;
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0)
            $display("FAIL add_lat1: v=%b busy=%b rdy=%b want 0 1 0",
                     res_valid, busy, cmd_ready);
        else passed++;
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_d !== 4'hC || res_cout !== 1'b0 || res_s !== 2'b01)
            $display("FAIL add_res: v=%b d=%h c=%b s=%b want 1 c 0 01",
                     res_valid, res_d, res_cout, res_s);
        else passed++;
        total++;
        if (op_count !== 8'd1 || carry_count !== 8'd0 || busy !== 1'b0)
            $display("FAIL add_cnt: op=%0d cc=%0d busy=%b want 1 0 0",
                     op_count, carry_count, busy);
        else passed++;
    endtask

    task automatic test_sub_inc();
        send_a(4'd9, 4'd3, 2'b10, 1'b1);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_d !== 4'h6 || res_cout !== 1'b1 || res_s !== 2'b10)
            $display("FAIL sub_res: v=%b d=%h c=%b s=%b want 1 6 1 10",
                     res_valid, res_d, res_cout, res_s);
        else passed++;
        total++;
        if (op_count !== 8'd2 || carry_count !== 8'd1)
            $display("FAIL sub_cnt: op=%0d cc=%0d want 2 1", op_count, carry_count);
        else passed++;
        send_a(4'd9, 4'd3, 2'b00, 1'b1);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (res_d !== 4'hA || res_cout !== 1'b0 || res_s !== 2'b00)
            $display("FAIL inc_res: d=%h c=%b s=%b want a 0 00", res_d, res_cout, res_s);
        else passed++;
    endtask

    task automatic test_all_ones();
        send_a(4'd0, 4'd5, 2'b11, 1'b0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (res_d !== 4'hF || res_cout !== 1'b0)
            $display("FAIL ones0_res: d=%h c=%b want f 0", res_d, res_cout);
        else passed++;
        send_a(4'd9, 4'd5, 2'b11, 1'b1);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (res_d !== 4'h9 || res_cout !== 1'b1 || res_s !== 2'b11)
            $display("FAIL ones9_res: d=%h c=%b s=%b want 9 1 11", res_d, res_cout, res_s);
        else passed++;
        total++;
        if (op_count !== 8'd5 || carry_count !== 8'd2)
            $display("FAIL ones_cnt: op=%0d cc=%0d want 5 2", op_count, carry_count);
        else passed++;
        @(negedge clk);
        total++;
        if (au_x !== 4'd9 || au_s !== 2'b11 || au_cin !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL hold_au: au_x=%h s=%b cin=%b v=%b want 9 11 1 0",
                     au_x, au_s, au_cin, res_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        total++;
        if (op_count !== 8'd0 || carry_count !== 8'd0)
            $display("FAIL clr_idle: op=%0d cc=%0d want 0 0", op_count, carry_count);
        else passed++;
        send_a(4'd1, 4'd2, 2'b01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_d !== 4'h3 || op_count !== 8'd1)
            $display("FAIL bp_first: v=%b d=%h op=%0d want 1 3 1",
                     res_valid, res_d, op_count);
        else passed++;
        // cmd_* changes while cmd_valid=0 have no effect
        cmd_x = 4'hE;
        send_a(4'd5, 4'd6, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (res_valid !== 1'b1 || res_d !== 4'h3 || res_s !== 2'b01)
                $display("FAIL bp_hold%0d: v=%b d=%h want 1 3", i, res_valid, res_d);
            else passed++;
        end
        total++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1 || op_count !== 8'd1)
            $display("FAIL bp_stall: rdy=%b busy=%b op=%0d want 0 1 1",
                     cmd_ready, busy, op_count);
        else passed++;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b1 || res_d !== 4'hB || op_count !== 8'd2 || busy !== 1'b0)
            $display("FAIL bp_swap: v=%b d=%h op=%0d busy=%b want 1 b 2 0",
                     res_valid, res_d, op_count, busy);
        else passed++;
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_d !== 4'hB)
            $display("FAIL bp_keep: v=%b d=%h want 1 b", res_valid, res_d);
        else passed++;
        res_ready = 1'b1;
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0)
            $display("FAIL bp_pop: v=%b want 0", res_valid);
        else passed++;
    endtask

    task automatic test_stat_clr();
        for (int i = 0; i < 3; i++) begin
            send_a(4'd1, 4'd1, 2'b01, 1'b0);
            @(negedge clk);
            @(negedge clk);
        end
        total++;
        if (op_count !== 8'd5 || carry_count !== 8'd0)
            $display("FAIL clr_pre: op=%0d cc=%0d want 5 0", op_count, carry_count);
        else passed++;
        send_a(4'hF, 4'h1, 2'b01, 1'b0);
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        total++;
        if (op_count !== 8'd0 || carry_count !== 8'd0)
            $display("FAIL clr_cap: op=%0d cc=%0d want 0 0", op_count, carry_count);
        else passed++;
        total++;
        if (res_valid !== 1'b1 || res_d !== 4'h0 || res_cout !== 1'b1)
            $display("FAIL clr_res: v=%b d=%h c=%b want 1 0 1",
                     res_valid, res_d, res_cout);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        @(negedge clk);
        cmd_x = 4'd2; cmd_y = 4'd2; cmd_s = 2'b01; cmd_cin = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (cmd_ready) acc++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        total++;
        if (acc !== 3)
            $display("FAIL b2b_accepts: got %0d want 3", acc);
        else passed++;
        total++;
        if (op_count !== 8'd3 || res_valid !== 1'b1 || res_d !== 4'h4)
            $display("FAIL b2b_res: op=%0d v=%b d=%h want 3 1 4",
                     op_count, res_valid, res_d);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        send_b(4'd9, 4'd3, 2'b01, 1'b0);
        @(negedge clk);
        total++;
        if (b_busy !== 1'b1 || b_au_x !== 4'd9)
            $display("FAIL mid_pre: busy=%b au_x=%h want 1 9", b_busy, b_au_x);
        else passed++;
        b_rst_n = 1'b0;
        #1;
        total++;
        if ({b_busy, b_res_valid, b_au_x, b_au_y, b_au_a, b_au_b,
             b_op_count, b_carry_count} !== 15'd0)
            $display("FAIL mid_rst: busy=%b v=%b au_x=%h op=%0d want 0",
                     b_busy, b_res_valid, b_au_x, b_op_count);
        else passed++;
        @(negedge clk);
        b_rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (b_res_valid !== 1'b0 || b_op_count !== 2'd0 || b_busy !== 1'b0)
            $display("FAIL mid_drop: v=%b op=%0d busy=%b want 0 0 0",
                     b_res_valid, b_op_count, b_busy);
        else passed++;
        send_b(4'd9, 4'd3, 2'b01, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if (b_res_valid !== 1'b0 || b_busy !== 1'b1)
            $display("FAIL s3_lat3: v=%b busy=%b want 0 1", b_res_valid, b_busy);
        else passed++;
        @(negedge clk);
        total++;
        if (b_res_valid !== 1'b1 || b_res_d !== 4'hC || b_op_count !== 2'd1)
            $display("FAIL s3_res: v=%b d=%h op=%0d want 1 c 1",
                     b_res_valid, b_res_d, b_op_count);
        else passed++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) begin
            send_b(4'hF, 4'hF, 2'b01, 1'b1);
            repeat (4) @(negedge clk);
        end
        total++;
        if (b_res_d !== 4'hF || b_res_cout !== 1'b1 || b_res_s !== 2'b01)
            $display("FAIL wrap_res: d=%h c=%b s=%b want f 1 01",
                     b_res_d, b_res_cout, b_res_s);
        else passed++;
        total++;
        if (b_op_count !== 2'd1 || b_carry_count !== 2'd0)
            $display("FAIL wrap_cnt: op=%0d cc=%0d want 1 0",
                     b_op_count, b_carry_count);
        else passed++;
        total++;
        if (b_au_a !== 1'b1 || b_au_b !== 1'b1)
            $display("FAIL wrap_ab: a=%b b=%b want 1 1", b_au_a, b_au_b);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0; b_rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_s = '0;
        cmd_cin = 1'b0; cmd_a = 1'b0; cmd_b = 1'b0;
        res_ready = 1'b1; stat_clr = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_x = '0; b_cmd_y = '0; b_cmd_s = '0;
        b_cmd_cin = 1'b0; b_res_ready = 1'b1; b_stat_clr = 1'b0;
        test_reset();
        test_add();
        test_sub_inc();
        test_all_ones();
        test_backpressure();
        test_stat_clr();
        test_back_to_back();
        test_reset_mid_op();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
